// File: rtl/uart_irq_ctrl_if.sv
// UART interrupt controller register/event bundle.
// master drives events and register writes; slave is the controller.
interface uart_irq_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] ev_i;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wd;
    logic             clr_we;
    logic [N_SRC-1:0] clr_wd;
    logic [N_SRC-1:0] mask_o;
    logic [N_SRC-1:0] pend_o;
    logic [N_SRC-1:0] stat_o;
    logic             irq;

    modport master (
        output ev_i, mask_we, mask_wd, clr_we, clr_wd,
        input  mask_o, pend_o, stat_o, irq
    );

    modport slave (
        input  ev_i, mask_we, mask_wd, clr_we, clr_wd,
        output mask_o, pend_o, stat_o, irq
    );
endinterface

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: edge-latched pending bits, mask, single irq.
// Define UART_IRQ_HOLDOFF_EN to compile in the post-deassert hold-off timer.
module uart_irq_ctrl #(
    parameter int N_SRC   = 4,
    parameter int HOLDOFF = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_irq_ctrl_if.slave bus
);
    logic [N_SRC-1:0] ev_q;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] stat;

    assign rise = bus.ev_i & ~ev_q;
    assign clr  = bus.clr_we ? bus.clr_wd : '0;
    assign stat = pend & mask;

    assign bus.mask_o = mask;
    assign bus.pend_o = pend;
    assign bus.stat_o = stat;

`ifdef UART_IRQ_HOLDOFF_EN
    localparam int CW =
        ($clog2(HOLDOFF + 1) < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] CNT_LOAD =
        CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD
    } state_t;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
`else
    localparam int unused_holdoff = HOLDOFF;

    typedef enum logic {
        S_IDLE,
        S_ASSERT
    } state_t;
`endif

    state_t state;
    state_t state_nxt;

    // Set wins over a same-cycle clear of the same bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ev_q  <= '0;
            pend  <= '0;
            mask  <= '0;
            state <= S_IDLE;
        end else begin
            ev_q  <= bus.ev_i;
            pend  <= (pend & ~clr) | rise;
            if (bus.mask_we) begin
                mask <= bus.mask_wd;
            end
            state <= state_nxt;
        end
    end

`ifdef UART_IRQ_HOLDOFF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
`ifdef UART_IRQ_HOLDOFF_EN
        cnt_nxt   = cnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (|stat) begin
                    state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (stat == '0) begin
`ifdef UART_IRQ_HOLDOFF_EN
                    if (HOLDOFF > 0) begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef UART_IRQ_HOLDOFF_EN
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.irq = (state == S_ASSERT);
endmodule
